// File: rtl/shared_pkg.sv
// Shared types and default sizing for the SPI-side RAM.
// Control field encoding of each received SPI word.
package shared_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } control_e;

    localparam int DEF_MEM_WIDTH = 8;
    localparam int DEF_MEM_DEPTH = 256;

endpackage

// File: rtl/spi_ram_core.sv
// Storage array: one write or one registered read per cycle; parity bit stored under RAM_PARITY_EN.
// Latency: read data one edge after re.
// Backpressure: none, every request is taken on the cycle it is presented.
module spi_ram_core #(
    parameter int DW    = 8,
    parameter int PW    = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
`ifdef RAM_PARITY_EN
    input  logic          par_inj,
`endif
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic          rd_vld,
    output logic [PW-1:0] rd_dat
);

    logic [PW-1:0] mem [DEPTH];
    logic [PW-1:0] wword;
    logic [PW-1:0] rword;
    logic [PW-1:0] mem_rd;

    assign mem_rd = mem[raddr];

`ifdef RAM_PARITY_EN
    // Stored top bit is even parity; on read it becomes a mismatch flag.
    assign wword = {(^wdata) ^ par_inj, wdata};
    assign rword = {(^mem_rd[DW-1:0]) ^ mem_rd[DW], mem_rd[DW-1:0]};
`else
    assign wword = wdata;
    assign rword = mem_rd;
`endif

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wword;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_dat <= '0;
        end else begin
            rd_vld <= re;
            if (re)
                rd_dat <= rword;
        end
    end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI-side RAM: decodes control field into address/data ops, burst auto-increment, range check (RAM_PARITY_EN adds parity).
// Latency: RD_DATA to tx_valid is RD_LATENCY edges, fully pipelined.
// Backpressure: none, one command accepted on every rx_valid cycle.
module spi_ram_burst
    import shared_pkg::*;
#(
    parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE  = $clog2(MEM_DEPTH),
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [MEM_WIDTH+1:0] rx_data,
    input  logic                 auto_inc,
    output logic                 tx_valid,
    output logic [MEM_WIDTH-1:0] dout,
`ifdef RAM_PARITY_EN
    input  logic                 par_inj,
    output logic                 par_err,
`endif
    output logic                 addr_err
);

`ifdef RAM_PARITY_EN
    localparam int PW = MEM_WIDTH + 1;
`else
    localparam int PW = MEM_WIDTH;
`endif
    localparam logic [MEM_WIDTH:0]   DEPTH_LIM = (MEM_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    control_e               ctrl;
    logic [MEM_WIDTH-1:0]   d_in;
    logic                   in_range;
    logic [ADDR_SIZE-1:0]   wr_addr;
    logic [ADDR_SIZE-1:0]   rd_addr;
    logic                   core_vld;
    logic [PW-1:0]          core_dat;
    logic                   out_vld;
    logic [PW-1:0]          out_dat;

    assign ctrl     = control_e'(rx_data[MEM_WIDTH+1:MEM_WIDTH]);
    assign d_in     = rx_data[MEM_WIDTH-1:0];
    assign in_range = ({1'b0, d_in} < DEPTH_LIM);

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (rx_valid) begin
                case (ctrl)
                    WR_ADDR: if (in_range) wr_addr <= d_in[ADDR_SIZE-1:0];
                             else          addr_err <= 1'b1;
                    WR_DATA: if (auto_inc) wr_addr <= next_addr(wr_addr);
                    RD_ADDR: if (in_range) rd_addr <= d_in[ADDR_SIZE-1:0];
                             else          addr_err <= 1'b1;
                    RD_DATA: if (auto_inc) rd_addr <= next_addr(rd_addr);
                    default: ;
                endcase
            end
        end
    end

    // Gating with rst_n lets reset override a command on the same edge.
    spi_ram_core #(
        .DW    (MEM_WIDTH),
        .PW    (PW),
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_SIZE)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rst_n && rx_valid && ctrl == WR_DATA),
        .waddr   (wr_addr),
        .wdata   (d_in),
`ifdef RAM_PARITY_EN
        .par_inj (par_inj),
`endif
        .re      (rst_n && rx_valid && ctrl == RD_DATA),
        .raddr   (rd_addr),
        .rd_vld  (core_vld),
        .rd_dat  (core_dat)
    );

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign out_vld = core_vld;
            assign out_dat = core_dat;
        end else begin : g_pipe
            logic [RD_LATENCY-2:0] vld_q;
            logic [PW-1:0]         dat_q [RD_LATENCY-1];

            // Data stages load only with valid so the last one holds dout between reads.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < RD_LATENCY-1; i++)
                        dat_q[i] <= '0;
                end else begin
                    vld_q[0] <= core_vld;
                    if (core_vld)
                        dat_q[0] <= core_dat;
                    for (int i = 1; i < RD_LATENCY-1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        if (vld_q[i-1])
                            dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign out_vld = vld_q[RD_LATENCY-2];
            assign out_dat = dat_q[RD_LATENCY-2];
        end
    endgenerate

    assign tx_valid = out_vld;
    assign dout     = out_dat[MEM_WIDTH-1:0];
`ifdef RAM_PARITY_EN
    assign par_err  = out_vld & out_dat[MEM_WIDTH];
`endif

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised single-port RAM behind the SPI slave, next generation of the SPI-side RAM. Decodes the 2-bit control field of each received word into address/data operations, adds optional address auto-increment for burst transfers, a configurable read pipeline and address range checking. Sits between the SPI slave's rx_data/rx_valid output and its tx_data/tx_valid input.

## Interface
- MEM_WIDTH, 8, data word width; MEM_WIDTH >= ADDR_SIZE required.
- MEM_DEPTH, 256, number of words; need not be a power of two.
- ADDR_SIZE, $clog2(MEM_DEPTH), address register width.
- RD_LATENCY, 1, edges from RD_DATA acceptance to tx_valid; legal 1..4.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rx_valid  in  1  rx_data valid this cycle.
- rx_data  in  MEM_WIDTH+2  [MEM_WIDTH+1:MEM_WIDTH] control, [MEM_WIDTH-1:0] d_in.
- auto_inc  in  1  burst mode; sampled with each accepted data command.
- tx_valid  out  1  one-cycle pulse, dout holds new read data.
- dout  out  MEM_WIDTH  read data; holds until next read completes.
- addr_err  out  1  one-cycle pulse, rejected address.

## Operation
- Command accepted only on a cycle with rx_valid=1; rx_valid=0 → no state change.
- Control 00 WR_ADDR: if d_in < MEM_DEPTH, wr_addr <= d_in[ADDR_SIZE-1:0]; else wr_addr unchanged, addr_err pulses.
- 01 WR_DATA: mem[wr_addr] <= d_in; if auto_inc, wr_addr <= (wr_addr==MEM_DEPTH-1) ? 0 : wr_addr+1.
- 10 RD_ADDR: same rules as WR_ADDR applied to rd_addr.
- 11 RD_DATA: reads mem[rd_addr] into the read pipeline; if auto_inc, rd_addr increments with the same wrap rule.
- Read pipeline is RD_LATENCY deep, fully pipelined: back-to-back RD_DATA on consecutive cycles produce back-to-back tx_valid pulses, in order.
- Write-then-read same address on consecutive cycles returns the newly written data.
- Unwritten locations read as X in simulation; no memory initialisation.
- Reset: tx_valid=0, dout=0, addr_err=0, wr_addr=0, rd_addr=0, read pipeline flushed (in-flight reads dropped, no tx_valid). Memory contents retained.

## Timing
- RD_DATA sampled at edge k → dout updated and tx_valid=1 after edge k+RD_LATENCY-1, low after the next edge unless another read completes.
- RD_LATENCY=1 matches the previous-generation registered behaviour.
- addr_err asserted after the edge that samples the bad WR_ADDR/RD_ADDR, for one cycle.
- Address registers update at the accepting edge; the next cycle's command uses the new value.
- rst_n low at an edge overrides any command on that edge.

## Configuration
- RAM_PARITY_EN defined: each word stores an extra even-parity bit; adds input par_inj (1 bit, inverts stored parity on a WR_DATA accepted while high) and output par_err (asserted with tx_valid when stored parity mismatches returned data; reset 0).
- RAM_PARITY_EN undefined: no parity storage, ports par_inj/par_err absent, behaviour otherwise identical.

## Structure
- shared_pkg: control_e (WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11), default MEM_WIDTH/MEM_DEPTH constants.
- Sub-module spi_ram_core: storage array, one write or one registered read per cycle, parity bit under the macro; top holds decode, address registers, wrap logic, range check and read pipeline.

## Test plan
- Reset then WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA → tx_valid one pulse after RD_LATENCY, dout=0xA5.
- auto_inc=1, WR_ADDR 0xFE, WR_DATA 0x11,0x22,0x33 → mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap).
- MEM_DEPTH=200: WR_ADDR 0xC8 → addr_err pulse, wr_addr keeps prior value; WR_ADDR 0xC7 accepted, no addr_err.
- RD_LATENCY=3, four consecutive RD_DATA with auto_inc → four consecutive tx_valid pulses, data in address order.
- Reset asserted two cycles after RD_DATA with RD_LATENCY=4 → no tx_valid, dout=0, addresses 0, previously written data still readable.
- RAM_PARITY_EN: WR_DATA 0x3C with par_inj=1, read back → dout=0x3C, par_err=1 with tx_valid; clean word → par_err=0.
